// File: rtl/pdm_modulator.sv
// Purpose: first-order sigma-delta PDM modulator with a one-sample PCM holding register and a generated bit clock.
// Latency: each dat_o bit is registered on an sclk fall event; a sample leaves holding at the next frame start.
// Backpressure: rdy drops while holding is full; dv is ignored until the frame start that empties holding.
module pdm_modulator #(
  parameter int SCLK_HALF = 12,
  parameter int DECIM     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] dat_i,
  input  logic        dv,
  output logic        rdy,
  output logic        sclk,
  output logic        dat_o,
  output logic        underrun
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int FW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          sclk_q, sclk_d;
  logic          dat_q, dat_d;
  logic          underrun_q, underrun_d;
  logic          rdy_q, rdy_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   act_q, act_d;
  logic [15:0]   acc_q, acc_d;

  logic          div_term;
  logic          fall;
  logic          frame_start;
  logic          accept;
  logic [15:0]   u;
  logic [16:0]   s;

  // Divider, frame counter, holding/active sample handoff and the accumulator step.
  always_comb begin
    div_term    = (cnt_q == CW'(SCLK_HALF - 1));
    // A fall event is the enabled terminal count while sclk is currently high.
    fall        = en && div_term && sclk_q;
    frame_start = fall && (frm_q == '0);
    accept      = dv && rdy_q;

    cnt_d      = cnt_q;
    sclk_d     = sclk_q;
    frm_d      = frm_q;
    hold_d     = hold_q;
    act_d      = act_q;
    rdy_d      = rdy_q;
    underrun_d = 1'b0;
    acc_d      = acc_q;
    dat_d      = dat_q;

    if (en) begin
      if (div_term) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (fall) begin
      if (frm_q == FW'(DECIM - 1)) begin
        frm_d = '0;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end

    // Frame start looks at holding as it was before this edge; rdy_q low means full.
    if (frame_start) begin
      if (!rdy_q) begin
        act_d = hold_q;
        rdy_d = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // An accept coinciding with an empty-holding frame start refills for the next frame.
    if (accept) begin
      hold_d = dat_i;
      rdy_d  = 1'b0;
    end

    // Offset-binary input: flipping the sign bit adds 32768 modulo 2^16.
    u = act_d ^ 16'h8000;
    s = {1'b0, acc_q} + {1'b0, u};
    if (fall) begin
      acc_d = s[15:0];
      dat_d = s[16];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      frm_q      <= '0;
      sclk_q     <= 1'b0;
      dat_q      <= 1'b0;
      underrun_q <= 1'b0;
      rdy_q      <= 1'b1;
      hold_q     <= '0;
      act_q      <= '0;
      acc_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      frm_q      <= frm_d;
      sclk_q     <= sclk_d;
      dat_q      <= dat_d;
      underrun_q <= underrun_d;
      rdy_q      <= rdy_d;
      hold_q     <= hold_d;
      act_q      <= act_d;
      acc_q      <= acc_d;
    end
  end

  assign rdy      = rdy_q;
  assign sclk     = sclk_q;
  assign dat_o    = dat_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// Purpose: directed self-checking bench for pdm_modulator with default parameters.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: samples are offered only when the bench expects rdy, plus deliberate ignored offers.
module tb_pdm_modulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] dat_i;
  logic        dv;
  logic        rdy;
  logic        sclk;
  logic        dat_o;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pdm_modulator #(.SCLK_HALF(12), .DECIM(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dat_i    (dat_i),
    .dv       (dv),
    .rdy      (rdy),
    .sclk     (sclk),
    .dat_o    (dat_o),
    .underrun (underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until sclk is seen going 1 -> 0; cyc returns the number of edges taken.
  task automatic wait_fall(output int cyc);
    logic p;
    bit   seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      p = sclk;
      step();
      cyc++;
      if (p === 1'b1 && sclk === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fall_timeout: no sclk fall seen within %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; dv = 1'b0; dat_i = 16'h0000;
    step(); step();
    checks++; if (sclk !== 1'b0)     begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (dat_o !== 1'b0)    begin errors++; $display("FAIL reset_dat_o: got %b want 0", dat_o); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (rdy !== 1'b1)      begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
  endtask

  // Idle run: x = 0 gives alternating bits and an underrun at every frame start.
  task automatic test_idle();
    int   rise_at, fall_at, cyc, bad_bits, bad_per, urs;
    logic p;
    rise_at = 0; fall_at = 0;
    reset = 1'b1;
    for (int c = 1; c <= 30 && fall_at == 0; c++) begin
      p = sclk;
      step();
      if (p === 1'b0 && sclk === 1'b1 && rise_at == 0) rise_at = c;
      if (p === 1'b1 && sclk === 1'b0) fall_at = c;
    end
    checks++; if (rise_at != 12) begin errors++; $display("FAIL idle_rise: got cycle %0d want 12", rise_at); end
    checks++; if (fall_at != 24) begin errors++; $display("FAIL idle_fall: got cycle %0d want 24", fall_at); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_first_underrun: got %b want 1", underrun); end
    checks++; if (dat_o !== 1'b0) begin errors++; $display("FAIL idle_first_bit: got %b want 0", dat_o); end
    bad_bits = 0; bad_per = 0; urs = 0;
    for (int k = 1; k < 64; k++) begin
      wait_fall(cyc);
      if (dat_o !== 1'(k % 2)) bad_bits++;
      if (cyc != 24) bad_per++;
      if (underrun !== 1'b0) urs++;
    end
    checks++; if (bad_bits != 0) begin errors++; $display("FAIL idle_pattern: %0d bits differ from 0,1,0,1", bad_bits); end
    checks++; if (bad_per != 0)  begin errors++; $display("FAIL idle_period: %0d sclk periods not 24 clk", bad_per); end
    checks++; if (urs != 0)      begin errors++; $display("FAIL idle_mid_underrun: got %0d pulses want 0", urs); end
    wait_fall(cyc);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL idle_second_frame_underrun: got %b want 1", underrun); end
    checks++; if (dat_o !== 1'b0) begin errors++; $display("FAIL idle_second_frame_bit: got %b want 0", dat_o); end
  endtask

  // Min sample, then 16384 (0,1,1,1), then 32767 (0 then all ones), loaded back to back.
  task automatic test_loads();
    int cyc, ones, urs, bad;
    reset = 1'b0; step(); reset = 1'b1;
    dv = 1'b1; dat_i = 16'h8000; step(); dv = 1'b0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL min_rdy_low: got %b want 0", rdy); end
    wait_fall(cyc);
    checks++; if (cyc != 23)         begin errors++; $display("FAIL min_first_fall: got %0d cycles want 23", cyc); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL min_underrun: got %b want 0", underrun); end
    checks++; if (rdy !== 1'b1)      begin errors++; $display("FAIL min_rdy_return: got %b want 1", rdy); end
    ones = dat_o; urs = 0;
    dv = 1'b1; dat_i = 16'h4000; step(); dv = 1'b0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL quarter_accept_rdy: got %b want 0", rdy); end
    for (int k = 1; k < 64; k++) begin
      wait_fall(cyc);
      ones += dat_o;
      if (underrun !== 1'b0) urs++;
    end
    checks++; if (ones != 0) begin errors++; $display("FAIL min_frame_ones: got %0d want 0", ones); end
    checks++; if (urs != 0)  begin errors++; $display("FAIL min_frame_underrun: got %0d want 0", urs); end

    bad = 0;
    for (int k = 0; k < 64; k++) begin
      wait_fall(cyc);
      if (dat_o !== ((k % 4) != 0)) bad++;
      if (k == 0) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL quarter_underrun: got %b want 0", underrun); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL quarter_rdy: got %b want 1", rdy); end
        dv = 1'b1; dat_i = 16'h7FFF; step(); dv = 1'b0;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL quarter_pattern: %0d bits differ from 0,1,1,1", bad); end

    bad = 0;
    for (int k = 0; k < 64; k++) begin
      wait_fall(cyc);
      if (dat_o !== (k != 0)) bad++;
      if (k == 0) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL max_underrun: got %b want 0", underrun); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL max_pattern: %0d bits differ from 0 then ones", bad); end
  endtask

  // dv lands exactly on an empty-holding frame start; a second dv while full is dropped.
  task automatic test_same_cycle();
    int cyc, ones;
    repeat (23) step();
    dv = 1'b1; dat_i = 16'h8000;
    wait_fall(cyc);
    dv = 1'b0;
    checks++; if (cyc != 1)          begin errors++; $display("FAIL sc_alignment: got %0d cycles want 1", cyc); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL sc_underrun: got %b want 1", underrun); end
    checks++; if (dat_o !== 1'b1)    begin errors++; $display("FAIL sc_bit_old_sample: got %b want 1", dat_o); end
    checks++; if (rdy !== 1'b0)      begin errors++; $display("FAIL sc_rdy: got %b want 0", rdy); end
    dv = 1'b1; dat_i = 16'h4000; step(); dv = 1'b0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sc_ignored_rdy: got %b want 0", rdy); end
    ones = 0;
    for (int k = 1; k < 64; k++) begin
      wait_fall(cyc);
      ones += dat_o;
    end
    checks++; if (ones != 63) begin errors++; $display("FAIL sc_hold_frame_ones: got %0d want 63", ones); end
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      wait_fall(cyc);
      ones += dat_o;
      if (k == 0) begin
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL sc_load_underrun: got %b want 0", underrun); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sc_load_rdy: got %b want 1", rdy); end
      end
    end
    checks++; if (ones != 0) begin errors++; $display("FAIL sc_loaded_frame_ones: got %0d want 0", ones); end
    wait_fall(cyc);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL sc_ignored_dv_underrun: got %b want 1", underrun); end
    checks++; if (dat_o !== 1'b0)    begin errors++; $display("FAIL sc_next_bit: got %b want 0", dat_o); end
  endtask

  // Freeze with sclk high, resume from the held count, then reset mid-frame.
  task automatic test_freeze_reset();
    int   cyc, changes, urs;
    logic s0, d0;
    repeat (17) step();
    en = 1'b0;
    s0 = sclk; d0 = dat_o;
    checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL frz_sclk_high: got %b want 1", s0); end
    dv = 1'b1; dat_i = 16'h1234; step(); dv = 1'b0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL frz_accept: got rdy %b want 0", rdy); end
    changes = 0; urs = 0;
    repeat (99) begin
      step();
      if (sclk !== s0 || dat_o !== d0) changes++;
      if (underrun !== 1'b0) urs++;
    end
    checks++; if (changes != 0) begin errors++; $display("FAIL frz_outputs: %0d cycles changed want 0", changes); end
    checks++; if (urs != 0)     begin errors++; $display("FAIL frz_underrun: got %0d pulses want 0", urs); end
    en = 1'b1;
    wait_fall(cyc);
    checks++; if (cyc != 7) begin errors++; $display("FAIL frz_resume: fall after %0d cycles want 7", cyc); end
    repeat (3) step();
    reset = 1'b0; step();
    checks++; if (sclk !== 1'b0)     begin errors++; $display("FAIL rst2_sclk: got %b want 0", sclk); end
    checks++; if (dat_o !== 1'b0)    begin errors++; $display("FAIL rst2_dat_o: got %b want 0", dat_o); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst2_underrun: got %b want 0", underrun); end
    checks++; if (rdy !== 1'b1)      begin errors++; $display("FAIL rst2_rdy: got %b want 1", rdy); end
    reset = 1'b1;
    wait_fall(cyc);
    checks++; if (cyc != 24)         begin errors++; $display("FAIL rst2_first_fall: got %0d cycles want 24", cyc); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL rst2_frame_start: got %b want 1", underrun); end
    checks++; if (dat_o !== 1'b0)    begin errors++; $display("FAIL rst2_bit0: got %b want 0", dat_o); end
    wait_fall(cyc);
    checks++; if (dat_o !== 1'b1)    begin errors++; $display("FAIL rst2_bit1: got %b want 1", dat_o); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_loads();
    test_same_cycle();
    test_freeze_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
